// File: rtl/avaliador_passo_polifonico_if.sv
// Handshake/bus bundle between the game controller and the step scorer.
// master: controller side (drives step, beat and key inputs).
// slave : scorer side (drives busy, LED feedback, verdict and error count).
interface avaliador_passo_polifonico_if #(
    parameter int KEYS    = 12,
    parameter int TEMPO_W = 4,
    parameter int ERRO_W  = 3
);
    logic               inicia;
    logic               aborta;
    logic               zera_erros;
    logic               metro_tick;
    logic [KEYS-1:0]    teclas;
    logic [KEYS-1:0]    nota_esperada;
    logic [TEMPO_W-1:0] tempo_esperado;
    logic               ocupado;
    logic [KEYS-1:0]    leds;
    logic [1:0]         resultado;
    logic               resultado_ok;
    logic [ERRO_W-1:0]  erros;
    logic               limite_erros;

    modport master (
        output inicia, aborta, zera_erros, metro_tick,
        output teclas, nota_esperada, tempo_esperado,
        input  ocupado, leds, resultado, resultado_ok,
        input  erros, limite_erros
    );

    modport slave (
        input  inicia, aborta, zera_erros, metro_tick,
        input  teclas, nota_esperada, tempo_esperado,
        output ocupado, leds, resultado, resultado_ok,
        output erros, limite_erros
    );
endinterface

// File: rtl/avaliador_passo_polifonico.sv
// Polyphonic song-step scorer: compares the accumulated key chord and the
// beat-timed hold duration against the expected step, issues a 2-bit verdict
// and keeps a saturating error count.
// Ports: clock, reset (async, active-high), bus (slave modport) carrying
//   inicia/aborta/zera_erros/metro_tick/teclas/nota_esperada/tempo_esperado
//   in, ocupado/leds/resultado/resultado_ok/erros/limite_erros out.
module avaliador_passo_polifonico #(
    parameter int KEYS          = 12,
    parameter int TEMPO_W       = 4,
    parameter int TOL_BEATS     = 0,
    parameter int TIMEOUT_BEATS = 8,
    parameter int ERRO_W        = 3,
    parameter int MAX_ERROS     = 3
) (
    input logic                         clock,
    input logic                         reset,
    avaliador_passo_polifonico_if.slave bus
);
    localparam int WAIT_W = $clog2(TIMEOUT_BEATS + 1);
    localparam int HELD_W = TEMPO_W + 1;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_BEATS - 1);
    localparam logic [HELD_W-1:0] HELD_MAX  = '1;
    localparam logic [HELD_W-1:0] TOL       = HELD_W'(TOL_BEATS);
    localparam logic [ERRO_W-1:0] ERRO_MAX  = '1;
    localparam logic [ERRO_W-1:0] ERRO_LIM  = ERRO_W'(MAX_ERROS);

    localparam logic [1:0] V_OK      = 2'b00;
    localparam logic [1:0] V_NOTA    = 2'b01;
    localparam logic [1:0] V_TEMPO   = 2'b10;
    localparam logic [1:0] V_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD,
        ST_REPORT
    } state_t;

    state_t               state;
    logic [KEYS-1:0]      exp_mask;
    logic [TEMPO_W-1:0]   exp_tempo;
    logic [KEYS-1:0]      acc_mask;
    logic [HELD_W-1:0]    held;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [1:0]           resultado;
    logic                 resultado_ok;
    logic [ERRO_W-1:0]    erros;

    logic [HELD_W-1:0]    exp_ext;
    logic [HELD_W-1:0]    diff;
    logic [1:0]           veredito;
    logic                 pressed;

    assign pressed = |bus.teclas;
    assign exp_ext = {1'b0, exp_tempo};

    // Larger-minus-smaller keeps the difference unsigned.
    always_comb begin
        diff = '0;
        if (held >= exp_ext) diff = held - exp_ext;
        else                 diff = exp_ext - held;
    end

    // Note mismatch outranks tempo mismatch.
    always_comb begin
        veredito = V_OK;
        if (acc_mask != exp_mask) veredito = V_NOTA;
        else if (diff > TOL)      veredito = V_TEMPO;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            exp_mask     <= '0;
            exp_tempo    <= '0;
            acc_mask     <= '0;
            held         <= '0;
            wait_cnt     <= '0;
            resultado    <= V_OK;
            resultado_ok <= 1'b0;
            erros        <= '0;
        end else begin
            resultado_ok <= 1'b0;
            if (bus.zera_erros) erros <= '0;

            if (bus.aborta) begin
                state <= ST_IDLE;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (bus.inicia) begin
                            exp_mask  <= bus.nota_esperada;
                            exp_tempo <= bus.tempo_esperado;
                            acc_mask  <= '0;
                            held      <= '0;
                            wait_cnt  <= '0;
                            state     <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        // A press in the final timeout tick still wins.
                        if (pressed) begin
                            acc_mask <= bus.teclas;
                            held     <= '0;
                            state    <= ST_HOLD;
                        end else if (bus.metro_tick) begin
                            if (wait_cnt == WAIT_LAST) begin
                                resultado    <= V_TIMEOUT;
                                resultado_ok <= 1'b1;
                                state        <= ST_REPORT;
                            end else begin
                                wait_cnt <= wait_cnt + 1'b1;
                            end
                        end
                    end
                    ST_HOLD: begin
                        // Release cycle: verdict out now, its tick dropped.
                        if (!pressed) begin
                            resultado    <= veredito;
                            resultado_ok <= 1'b1;
                            state        <= ST_REPORT;
                        end else begin
                            acc_mask <= acc_mask | bus.teclas;
                            if (bus.metro_tick && held != HELD_MAX)
                                held <= held + 1'b1;
                        end
                    end
                    ST_REPORT: begin
                        if (!bus.zera_erros && resultado != V_OK &&
                            erros != ERRO_MAX)
                            erros <= erros + 1'b1;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        bus.leds = '0;
        if (state == ST_HOLD)      bus.leds = acc_mask;
        else if (state == ST_WAIT) bus.leds = exp_mask;
    end

    assign bus.ocupado      = (state != ST_IDLE);
    assign bus.resultado    = resultado;
    assign bus.resultado_ok = resultado_ok;
    assign bus.erros        = erros;
    assign bus.limite_erros = (erros >= ERRO_LIM);
endmodule

// File: tb/tb_avaliador_passo_polifonico.sv
// Directed bench for the polyphonic step scorer, two instances differing
// only in beat tolerance (0 and 2), checked against a verdict scoreboard.
module tb_avaliador_passo_polifonico;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    avaliador_passo_polifonico_if #(.KEYS(12), .TEMPO_W(4), .ERRO_W(3)) b1 ();
    avaliador_passo_polifonico_if #(.KEYS(12), .TEMPO_W(4), .ERRO_W(3)) b2 ();

    assign b2.inicia         = b1.inicia;
    assign b2.aborta         = b1.aborta;
    assign b2.zera_erros     = b1.zera_erros;
    assign b2.metro_tick     = b1.metro_tick;
    assign b2.teclas         = b1.teclas;
    assign b2.nota_esperada  = b1.nota_esperada;
    assign b2.tempo_esperado = b1.tempo_esperado;

    avaliador_passo_polifonico #(.TOL_BEATS(0)) dut1 (
        .clock(clock), .reset(reset), .bus(b1.slave));
    avaliador_passo_polifonico #(.TOL_BEATS(2)) dut2 (
        .clock(clock), .reset(reset), .bus(b2.slave));

    int n_chk = 0;
    int n_err = 0;

    logic [1:0] q1[$];
    logic [1:0] q2[$];
    int         exp_erros[2];
    logic [1:0] last_v[2];

    logic [11:0] m_exp, m_acc;
    int          m_tempo, m_held;

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Spec rules: note mismatch first, then |held-expected| vs tolerance.
    function automatic logic [1:0] verdict(logic [11:0] acc, logic [11:0] ex,
                                           int held, int tempo, int tol);
        int h, d;
        h = (held > 31) ? 31 : held;
        d = (h > tempo) ? h - tempo : tempo - h;
        if (acc != ex) return 2'b01;
        if (d > tol)   return 2'b10;
        return 2'b00;
    endfunction

    task automatic cmp(int k, logic ok, logic [1:0] res, logic [2:0] er, logic lim);
        logic [1:0] v;
        chk($sformatf("erros%0d", k), er, exp_erros[k]);
        chk($sformatf("limite%0d", k), lim, exp_erros[k] >= 3);
        if (ok) begin
            if (k == 0) begin
                chk("q1_nonempty", q1.size() > 0, 1);
                v = (q1.size() > 0) ? q1.pop_front() : 2'b00;
            end else begin
                chk("q2_nonempty", q2.size() > 0, 1);
                v = (q2.size() > 0) ? q2.pop_front() : 2'b00;
            end
            chk($sformatf("verdict%0d", k), res, v);
            last_v[k] = v;
            if (v != 2'b00 && exp_erros[k] < 7) exp_erros[k]++;
        end else begin
            chk($sformatf("hold_res%0d", k), res, last_v[k]);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            cmp(0, b1.resultado_ok, b1.resultado, b1.erros, b1.limite_erros);
            cmp(1, b2.resultado_ok, b2.resultado, b2.erros, b2.limite_erros);
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic start(logic [11:0] mask, int beats);
        b1.nota_esperada  = mask;
        b1.tempo_esperado = 4'(beats);
        b1.inicia = 1'b1;
        cyc(1);
        b1.inicia = 1'b0;
        m_exp = mask; m_tempo = beats; m_acc = '0; m_held = 0;
        chk("ocupado_start", b1.ocupado, 1);
        chk("leds_wait", b1.leds, mask);
    endtask

    task automatic keys(logic [11:0] k);
        b1.teclas = k;
        m_acc |= k;
        cyc(1);
    endtask

    task automatic hold_tick();
        b1.metro_tick = 1'b1;
        m_held++;
        cyc(1);
        b1.metro_tick = 1'b0;
    endtask

    task automatic wait_tick(bit last);
        b1.metro_tick = 1'b1;
        if (last) begin
            q1.push_back(2'b11);
            q2.push_back(2'b11);
        end
        cyc(1);
        b1.metro_tick = 1'b0;
    endtask

    task automatic release_keys();
        b1.teclas = '0;
        q1.push_back(verdict(m_acc, m_exp, m_held, m_tempo, 0));
        q2.push_back(verdict(m_acc, m_exp, m_held, m_tempo, 2));
        cyc(1);
        chk("ok_pulse", b1.resultado_ok, 1);
    endtask

    task automatic zera();
        b1.zera_erros = 1'b1;
        cyc(1);
        b1.zera_erros = 1'b0;
        exp_erros[0] = 0; exp_erros[1] = 0;
    endtask

    initial begin
        b1.inicia = 0; b1.aborta = 0; b1.zera_erros = 0; b1.metro_tick = 0;
        b1.teclas = '0; b1.nota_esperada = '0; b1.tempo_esperado = '0;
        exp_erros[0] = 0; exp_erros[1] = 0;
        last_v[0] = 2'b00; last_v[1] = 2'b00;
        cyc(2);
        reset = 1'b0;
        cyc(1);
        chk("rst_ocupado", b1.ocupado, 0);
        chk("rst_leds", b1.leds, 0);
        chk("rst_res", b1.resultado, 0);
        chk("rst_ok", b1.resultado_ok, 0);
        chk("rst_erros", b1.erros, 0);

        // T1 single note, exact tempo; busy inicia ignored
        start(12'h010, 2);
        b1.nota_esperada = 12'h800;
        b1.inicia = 1'b1;
        cyc(1);
        b1.inicia = 1'b0;
        chk("inicia_busy_leds", b1.leds, 12'h010);
        keys(12'h010);
        chk("leds_hold", b1.leds, 12'h010);
        hold_tick(); hold_tick();
        release_keys();
        chk("t1_res", b1.resultado, 2'b00);
        cyc(1);
        chk("t1_idle", b1.ocupado, 0);

        // T2 chord built up mid-hold
        start(12'h011, 1);
        keys(12'h001); keys(12'h011);
        chk("leds_acc", b1.leds, 12'h011);
        hold_tick();
        release_keys();
        chk("t2a_res", b1.resultado, 2'b00);
        cyc(1);
        start(12'h011, 1);
        keys(12'h001); keys(12'h111);
        hold_tick();
        release_keys();
        chk("t2b_res", b1.resultado, 2'b01);
        cyc(1);
        chk("t2b_erros", b1.erros, 1);

        // T3 held too long: tol 0 vs tol 2
        start(12'h004, 3);
        keys(12'h004);
        repeat (5) hold_tick();
        release_keys();
        chk("t3_res_tol0", b1.resultado, 2'b10);
        chk("t3_res_tol2", b2.resultado, 2'b00);
        cyc(1);

        // T4 timeout, then press on the final tick
        start(12'h008, 1);
        repeat (7) wait_tick(0);
        chk("t4_no_early", b1.resultado_ok, 0);
        wait_tick(1);
        chk("t4_ok", b1.resultado_ok, 1);
        chk("t4_res", b1.resultado, 2'b11);
        cyc(1);
        chk("t4_limite", b1.limite_erros, 1);
        start(12'h020, 0);
        repeat (7) wait_tick(0);
        b1.metro_tick = 1'b1;
        b1.teclas = 12'h020;
        m_acc = 12'h020;
        cyc(1);
        b1.metro_tick = 1'b0;
        chk("t4b_hold_ok", b1.resultado_ok, 0);
        chk("t4b_leds", b1.leds, 12'h020);
        release_keys();
        chk("t4b_res", b1.resultado, 2'b00);
        cyc(1);

        // inicia with aborta in IDLE stays idle
        b1.inicia = 1'b1; b1.aborta = 1'b1;
        cyc(1);
        b1.inicia = 1'b0; b1.aborta = 1'b0;
        chk("ini_abort_idle", b1.ocupado, 0);

        // T5 saturating errors
        zera();
        chk("zera1", b1.erros, 0);
        for (int i = 1; i <= 8; i++) begin
            start(12'h001, 0);
            keys(12'h002);
            release_keys();
            cyc(1);
            chk($sformatf("t5_erros_%0d", i), b1.erros, (i > 7) ? 7 : i);
            chk($sformatf("t5_lim_%0d", i), b1.limite_erros, i >= 3);
        end

        // T6 abort in HOLD keeps erros
        start(12'h040, 1);
        keys(12'h040);
        hold_tick();
        b1.aborta = 1'b1;
        cyc(1);
        b1.aborta = 1'b0;
        chk("abort_idle", b1.ocupado, 0);
        chk("abort_leds", b1.leds, 0);
        chk("abort_ok", b1.resultado_ok, 0);
        chk("abort_erros", b1.erros, 7);
        b1.teclas = '0;
        cyc(2);
        zera();
        chk("zera2", b1.erros, 0);

        // one error, then reset in WAIT_PRESS clears it
        start(12'h001, 0);
        keys(12'h003);
        release_keys();
        cyc(1);
        chk("pre_rst_erros", b1.erros, 1);
        start(12'h002, 2);
        reset = 1'b1;
        exp_erros[0] = 0; exp_erros[1] = 0;
        last_v[0] = 2'b00; last_v[1] = 2'b00;
        #1;
        chk("rst_mid_ocupado", b1.ocupado, 0);
        chk("rst_mid_leds", b1.leds, 0);
        chk("rst_mid_erros", b1.erros, 0);
        cyc(1);
        reset = 1'b0;
        cyc(3);
        chk("rst_mid_ok", b1.resultado_ok, 0);

        chk("q1_empty", q1.size(), 0);
        chk("q2_empty", q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
